sid_write_sequencer: RTL
========================

Name: sid_write_sequencer

Overview:
- Command-driven sequencer for the tt_um_sid register bus.
- Queues register writes and timed delays from a host-side source (SPI bridge, ROM player, bench), then replays them onto ui_in/uio_in with the exact write-strobe timing the SID core expects.
- Makes gate-on/gate-off note playback and ADSR/filter setup a pushed command list instead of hand-timed bus wiggling.

Parameters:
- DEPTH, 8: command FIFO entries; power of two, ≥2.
- STROBE_CYCLES, 2: cycles ui_in[7] is held high per write; ≥1.
- TICK_CYCLES, 24000: clk cycles per delay tick (1 ms at 24 MHz); ≥1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept; equals !full.
- cmd_wait  in  1  0 = register write, 1 = delay.
- cmd_voice  in  2  voice select (3 = filter/global block).
- cmd_addr  in  3  register address.
- cmd_data  in  8  write data.
- bus_ctrl  out  8  to SID ui_in: {strobe, 2'b00, voice, addr}.
- bus_data  out  8  to SID uio_in.
- busy  out  1  FSM not IDLE, or FIFO non-empty.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (async, rst_n low): FIFO empty, level=0, FSM IDLE, bus_ctrl=0, bus_data=0, busy=0, cmd_ready=1. Reset mid-write drops strobe immediately; queued commands are lost.
- All bus outputs are registered. bus_ctrl[6:5] is always 0.
- Push: cmd_valid && cmd_ready at a posedge stores {wait, voice, addr, data}.
  - cmd_ready depends only on full; there is no same-cycle pass-through when full, even if a pop occurs in that cycle.
  - Push and pop in the same cycle leave level unchanged.
- Delay count: the 13-bit concatenation {voice, addr, data}.
- FSM states: IDLE, SETUP, STROBE, HOLD, WAIT.
- IDLE:
  - FIFO non-empty → pop head.
  - Write entry → SETUP. Delay entry → WAIT, with the cycle counter loaded to count×TICK_CYCLES.
  - A command pushed into an empty FIFO at edge N pops at edge N+1; its SETUP values appear after edge N+1.
- SETUP (1 cycle): bus_ctrl = {0, 00, voice, addr}, bus_data = data → STROBE.
- STROBE (STROBE_CYCLES cycles): bus_ctrl[7]=1; address and data unchanged → HOLD.
- HOLD (1 cycle): bus_ctrl[7]=0; address and data unchanged.
  - Then pop the next entry if available and go directly to SETUP/WAIT (no IDLE bubble). Otherwise → IDLE.
- Timing: one write = 2+STROBE_CYCLES cycles (4 by default). Back-to-back writes present no gap between HOLD and the next SETUP.
- IDLE after a write: bus_ctrl[7]=0; voice/addr/data keep the last written values (no glitching to 0).
- WAIT:
  - Bus outputs held, strobe low.
  - Down-counts 1 per cycle; leaves when the counter reaches 0. Count 0 → exactly 1 cycle in WAIT.
  - Total WAIT cycles = max(1, count×TICK_CYCLES).
  - Counter width: ceil(log2(8191×TICK_CYCLES+1)); no overflow permitted.
- FIFO pointers wrap modulo DEPTH.
- Full: level == DEPTH. Empty: level == 0.
- busy falls to 0 in the same cycle the FSM returns to IDLE with the FIFO empty.

Test Plan:
- Reset → single write (voice 0, addr 6, data 0x11) → bus_ctrl 0x06 for 1 cycle, 0x86 for 2 cycles, 0x06 for 1 cycle; bus_data 0x11 throughout; busy low on the next cycle.
- Push 10 writes (voice 3, addr 0–3, data 0x00/0x00/0x00/0x0F …) at full rate, DEPTH=8 → cmd_ready low at level 8; all 10 appear in order, 4 cycles each, no gaps; exactly 10 strobe pulses.
- Delay with count 5, TICK_CYCLES=4 (bench override) between two writes → second SETUP begins 20 cycles after the first HOLD; strobe low throughout the wait.
- Delay with count 0 → exactly 1 WAIT cycle between the surrounding writes.
- rst_n asserted during STROBE with 3 queued → bus_ctrl=0 asynchronously; level=0; after release, no further strobes.
- Scripted note: writes 0x24/0x00/0x00/0x08/0x99/0xA9 to voice 0 addr 0–5, 0x11 to addr 6, delay 1000, 0x10 to addr 6 → SID model sees gate rise, then gate clear 1000×TICK_CYCLES+1 cycles after the 0x11 HOLD.

Source files
------------

// File: rtl/sid_write_sequencer.sv
// ---------------------------------------------------------------------------
// sid_write_sequencer
//
// Command-driven sequencer for the tt_um_sid register bus. A host pushes
// register writes and timed delays into a small FIFO; the sequencer replays
// them onto the SID's ui_in/uio_in pins with the strobe timing the core
// expects:
//   write: SETUP (1 cycle) -> STROBE (STROBE_CYCLES) -> HOLD (1 cycle)
//   delay: WAIT for max(1, count * TICK_CYCLES) cycles
// Back-to-back commands are chained straight out of HOLD/WAIT with no idle
// cycle in between.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   cmd_valid  in   command present
//   cmd_ready  out  FIFO can accept (not full)
//   cmd_wait   in   0 = register write, 1 = delay
//   cmd_voice  in   voice select (3 = filter/global block)
//   cmd_addr   in   register address
//   cmd_data   in   write data
//   bus_ctrl   out  to SID ui_in: {strobe, 2'b00, voice, addr}
//   bus_data   out  to SID uio_in
//   busy       out  sequencer active or commands queued
//   level      out  FIFO occupancy
// ---------------------------------------------------------------------------
module sid_write_sequencer #(
  parameter int DEPTH         = 8,
  parameter int STROBE_CYCLES = 2,
  parameter int TICK_CYCLES   = 24000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_wait,
  input  logic [1:0]             cmd_voice,
  input  logic [2:0]             cmd_addr,
  input  logic [7:0]             cmd_data,
  output logic [7:0]             bus_ctrl,
  output logic [7:0]             bus_data,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  // Largest delay is the full 13-bit count times the tick length; the wait
  // counter is sized so that product never overflows.
  localparam longint unsigned MAX_WAIT = 64'd8191 * 64'(TICK_CYCLES);
  localparam int CW = $clog2(MAX_WAIT + 64'd1);
  localparam int SW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_WAIT   = 3'd4
  } state_e;

  // FIFO storage and bookkeeping. Entry layout: {wait, voice, addr, data}.
  logic [13:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;

  state_e        state_q, state_d;
  logic [SW-1:0] strb_cnt_q, strb_cnt_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic [7:0]    ctrl_q, ctrl_d;
  logic [7:0]    data_q, data_d;

  logic          full_s, empty_s, push_s, pop_s, take_s;
  logic [13:0]   head_s;
  logic [CW-1:0] wait_load_s;

  assign full_s      = (level_q == LW'(DEPTH));
  assign empty_s     = (level_q == {LW{1'b0}});
  assign push_s      = cmd_valid && !full_s;
  assign head_s      = mem_q[rd_ptr_q];
  assign wait_load_s = CW'(head_s[12:0]) * CW'(TICK_CYCLES);

  assign cmd_ready = !full_s;
  assign busy      = (state_q != ST_IDLE) || !empty_s;
  assign level     = level_q;
  assign bus_ctrl  = ctrl_q;
  assign bus_data  = data_q;

  // FIFO payload write (storage needs no reset; occupancy gates every read).
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {cmd_wait, cmd_voice, cmd_addr, cmd_data};
    end
  end

  // FIFO pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1'b1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1'b1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LW'(1'b1);
      2'b01:   level_d = level_q - LW'(1'b1);
      default: level_d = level_q;
    endcase
  end

  // Sequencer next-state and registered bus values.
  always_comb begin
    state_d    = state_q;
    strb_cnt_d = strb_cnt_q;
    wait_cnt_d = wait_cnt_q;
    ctrl_d     = ctrl_q;
    data_d     = data_q;
    take_s     = 1'b0;
    pop_s      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!empty_s) begin
          take_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        ctrl_d[7]  = 1'b1;
        strb_cnt_d = SW'(STROBE_CYCLES - 1);
        state_d    = ST_STROBE;
      end
      ST_STROBE: begin
        if (strb_cnt_q == {SW{1'b0}}) begin
          ctrl_d[7] = 1'b0;
          state_d   = ST_HOLD;
        end else begin
          strb_cnt_d = strb_cnt_q - SW'(1'b1);
        end
      end
      ST_HOLD: begin
        if (!empty_s) begin
          take_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        // A loaded count of 0 or 1 both mean "this is the last WAIT cycle".
        if (wait_cnt_q <= CW'(1'b1)) begin
          if (!empty_s) begin
            take_s = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          wait_cnt_d = wait_cnt_q - CW'(1'b1);
        end
      end
      default: begin
        state_d   = ST_IDLE;
        ctrl_d[7] = 1'b0;
      end
    endcase

    // Dispatch the FIFO head; SETUP values land on the bus at this edge.
    if (take_s) begin
      pop_s = 1'b1;
      if (head_s[13]) begin
        state_d    = ST_WAIT;
        wait_cnt_d = wait_load_s;
      end else begin
        state_d = ST_SETUP;
        ctrl_d  = {1'b0, 2'b00, head_s[12:8]};
        data_d  = head_s[7:0];
      end
    end else begin
      pop_s = 1'b0;
    end
  end

  // State, counter, pointer and bus registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      strb_cnt_q <= {SW{1'b0}};
      wait_cnt_q <= {CW{1'b0}};
      ctrl_q     <= 8'h00;
      data_q     <= 8'h00;
      wr_ptr_q   <= {AW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      level_q    <= {LW{1'b0}};
    end else begin
      state_q    <= state_d;
      strb_cnt_q <= strb_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      ctrl_q     <= ctrl_d;
      data_q     <= data_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
    end
  end

endmodule
